// File: rtl/clk_slow_mon.sv
// Slow-clock monitor: synchronizes clk_sys_in, emits edge ticks, measures rise-to-rise period and detects stalls.
// Optional build macro CLK_SLOW_MON_JITTER_CHECK_EN adds a period mismatch pulse while locked.
module clk_slow_mon #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 400004
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_sys_in,
    output logic             rise_tick,
    output logic             fall_tick,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             stalled,
    output logic             period_err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_STALLED = 2'd3;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_p;
    logic                   r_rise;
    logic                   r_fall;
    logic [CNT_W-1:0]       r_cnt;
    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_period;
    logic                   r_period_valid;
    logic                   r_locked;
    logic                   r_stalled;

    logic                   w_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_timeout;
    logic                   w_meas;
    logic                   w_enter_stall;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [1:0]             w_state_nxt;

    assign w_s       = r_sync[SYNC_STAGES-1];
    assign w_rise    = w_s & ~r_p;
    assign w_fall    = ~w_s & r_p;
    assign w_timeout = (r_cnt == TIMEOUT_C);

    // Synchronizer chain plus one-cycle delayed copy for edge detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_p    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], clk_sys_in};
            r_p    <= w_s;
        end
    end

    // Registered edge ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_rise;
            r_fall <= w_fall;
        end
    end

    // Interval counter: restarts at 1 on a rise so its value at the next rise is the full period
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_rise) begin
            w_cnt_nxt = ONE_C;
        end else if (!w_timeout) begin
            w_cnt_nxt = r_cnt + ONE_C;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    // Next-state logic; a rise always wins over a coincident timeout
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise)         w_state_nxt = ST_MEASURE;
                else if (w_timeout) w_state_nxt = ST_STALLED;
                else                w_state_nxt = ST_IDLE;
            end
            ST_MEASURE: begin
                if (w_rise)         w_state_nxt = ST_LOCKED;
                else if (w_timeout) w_state_nxt = ST_STALLED;
                else                w_state_nxt = ST_MEASURE;
            end
            ST_LOCKED: begin
                if (w_rise)         w_state_nxt = ST_LOCKED;
                else if (w_timeout) w_state_nxt = ST_STALLED;
                else                w_state_nxt = ST_LOCKED;
            end
            ST_STALLED: begin
                if (w_rise)         w_state_nxt = ST_MEASURE;
                else                w_state_nxt = ST_STALLED;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_meas        = w_rise & ((r_state == ST_MEASURE) | (r_state == ST_LOCKED));
    assign w_enter_stall = (w_state_nxt == ST_STALLED) & (r_state != ST_STALLED);

    // State register with status flags decoded from the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_locked  <= 1'b0;
            r_stalled <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_locked  <= (w_state_nxt == ST_LOCKED);
            r_stalled <= (w_state_nxt == ST_STALLED);
        end
    end

    // Period capture; a rise from IDLE/STALLED only starts a new interval
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period       <= '0;
            r_period_valid <= 1'b0;
        end else begin
            if (w_meas) begin
                r_period       <= r_cnt;
                r_period_valid <= 1'b1;
            end else if (w_enter_stall) begin
                r_period_valid <= 1'b0;
            end else begin
                r_period_valid <= r_period_valid;
            end
        end
    end

`ifdef CLK_SLOW_MON_JITTER_CHECK_EN
    logic r_period_err;

    // Mismatch pulse aligned with the period update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_period_err <= 1'b0;
        end else begin
            r_period_err <= w_rise & (r_state == ST_LOCKED) & (r_cnt != r_period);
        end
    end

    assign period_err = r_period_err;
`else
    assign period_err = 1'b0;
`endif

    assign rise_tick    = r_rise;
    assign fall_tick    = r_fall;
    assign period       = r_period;
    assign period_valid = r_period_valid;
    assign locked       = r_locked;
    assign stalled      = r_stalled;

endmodule

// File: tb/tb_clk_slow_mon.sv
// Scoreboard bench for clk_slow_mon: expected per-rise status is queued at stimulus time, checked on each rise_tick.
module tb_clk_slow_mon;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_sys_in;
    logic        rise_tick;
    logic        fall_tick;
    logic [31:0] period;
    logic        period_valid;
    logic        locked;
    logic        stalled;
    logic        period_err;

`ifdef CLK_SLOW_MON_JITTER_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] per;
        logic        valid;
        logic        lock;
        logic        stall;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    clk_slow_mon #(.SYNC_STAGES(2), .CNT_W(32), .TIMEOUT(20)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_sys_in   (clk_sys_in),
        .rise_tick    (rise_tick),
        .fall_tick    (fall_tick),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .stalled      (stalled),
        .period_err   (period_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] per, input logic valid, input logic lock, input logic err);
        exp_t e;
        e.per   = per;
        e.valid = valid;
        e.lock  = lock;
        e.stall = 1'b0;
        e.err   = err;
        q.push_back(e);
    endtask

    // Monitor: every rise_tick pops one expected record
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset === 1'b0 && rise_tick === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_rise", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("period", period, e.per);
                check("period_valid", {31'd0, period_valid}, {31'd0, e.valid});
                check("locked", {31'd0, locked}, {31'd0, e.lock});
                check("stalled", {31'd0, stalled}, {31'd0, e.stall});
                check("period_err", {31'd0, period_err}, {31'd0, e.err});
            end
        end
    end

    task automatic measure(input string name, input bit is_rise);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            seen = is_rise ? rise_tick : fall_tick;
        end
        check({name, "_latency"}, n, 32'd3);
        @(posedge clk);
        #1;
        check({name, "_width"}, {31'd0, (is_rise ? rise_tick : fall_tick)}, 32'd0);
        @(negedge clk);
    endtask

    // One slow-clock period: high for h cycles, low for h cycles (lat=1 assumes h=4)
    task automatic cycle(input int h, input bit lat);
        clk_sys_in = 1'b1;
        if (lat) measure("rise", 1'b1);
        else repeat (h) @(negedge clk);
        clk_sys_in = 1'b0;
        if (lat) measure("fall", 1'b0);
        else repeat (h) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rise_tick"}, {31'd0, rise_tick}, 32'd0);
        check({tag, "_period"}, period, 32'd0);
        check({tag, "_period_valid"}, {31'd0, period_valid}, 32'd0);
        check({tag, "_locked"}, {31'd0, locked}, 32'd0);
        check({tag, "_stalled"}, {31'd0, stalled}, 32'd0);
        check({tag, "_period_err"}, {31'd0, period_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        clk_sys_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        check("reset_fall_tick", {31'd0, fall_tick}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Lock at period 8, then half-period 5 gives period 10
        push(32'd0, 1'b0, 1'b0, 1'b0);  cycle(4, 1'b1);
        push(32'd8, 1'b1, 1'b1, 1'b0);  cycle(4, 1'b0);
        push(32'd8, 1'b1, 1'b1, 1'b0);  cycle(4, 1'b0);
        push(32'd8, 1'b1, 1'b1, 1'b0);  cycle(4, 1'b0);
        push(32'd8, 1'b1, 1'b1, 1'b0);  cycle(5, 1'b0);
        push(32'd10, 1'b1, 1'b1, ERR_EXP); cycle(5, 1'b0);
        push(32'd10, 1'b1, 1'b1, 1'b0); cycle(5, 1'b0);

        // Hold low past the timeout
        repeat (30) @(negedge clk);
        check("stall_stalled", {31'd0, stalled}, 32'd1);
        check("stall_locked", {31'd0, locked}, 32'd0);
        check("stall_period_valid", {31'd0, period_valid}, 32'd0);
        check("stall_period", period, 32'd10);

        // Recovery: first rise only re-enters MEASURE
        push(32'd10, 1'b0, 1'b0, 1'b0); cycle(4, 1'b0);
        push(32'd8, 1'b1, 1'b1, 1'b0);  cycle(4, 1'b0);
        push(32'd8, 1'b1, 1'b1, 1'b0);  cycle(4, 1'b0);

        // Reset between rises while locked
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset = 1'b0;
        push(32'd0, 1'b0, 1'b0, 1'b0);  cycle(4, 1'b0);
        push(32'd8, 1'b1, 1'b1, 1'b0);  cycle(4, 1'b0);

        // Rise lands exactly when the counter reaches the timeout
        push(32'd8, 1'b1, 1'b1, 1'b0);  cycle(10, 1'b0);
        push(32'd20, 1'b1, 1'b1, ERR_EXP); cycle(10, 1'b0);
        push(32'd20, 1'b1, 1'b1, 1'b0); cycle(10, 1'b0);

        repeat (10) @(negedge clk);
        check("missing_rises", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_slow_mon.md
CLK_SLOW_MON -- requirements
Module: clk_slow_mon

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops, legal range 2..4.
REQ-002 SHALL have parameter CNT_W, default 32, width of the period counter and period output.
REQ-003 SHALL have parameter TIMEOUT, default 400004, fast cycles without a rising edge before stall is declared; range 2..2^CNT_W-2.
REQ-004 SHALL have port clk, input, 1, fast system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port clk_sys_in, input, 1, divided slow clock, asynchronous to clk.
REQ-007 SHALL have port rise_tick, output, 1, one-cycle pulse per detected slow-clock rising edge.
REQ-008 SHALL have port fall_tick, output, 1, one-cycle pulse per detected slow-clock falling edge.
REQ-009 SHALL have port period, output, CNT_W, last measured rise-to-rise interval in clk cycles.
REQ-010 SHALL have port period_valid, output, 1, period holds a complete measurement.
REQ-011 SHALL have port locked, output, 1, state is LOCKED.
REQ-012 SHALL have port stalled, output, 1, state is STALLED.
REQ-013 SHALL have port period_err, output, 1, one-cycle pulse on period mismatch (see Configuration).

Function
REQ-014 SHALL pass clk_sys_in through SYNC_STAGES flops; s = last stage, p = s delayed one cycle.
REQ-015 SHALL register rise_tick = s & ~p and fall_tick = ~s & p; latency from first clk edge sampling the new level to tick high = SYNC_STAGES+1 cycles.
REQ-016 SHALL keep counter cnt incremented every cycle, saturating at TIMEOUT; on a detected rise, cnt SHALL load 1.
REQ-017 SHALL implement FSM states IDLE, MEASURE, LOCKED, STALLED.
REQ-018 IDLE -> MEASURE on rise; MEASURE -> LOCKED on rise; LOCKED stays on rise; STALLED -> MEASURE on rise.
REQ-019 IDLE, MEASURE and LOCKED SHALL go to STALLED when cnt reaches TIMEOUT without a rise.
REQ-020 On a rise in MEASURE or LOCKED, period SHALL load cnt (interval including the edge cycle) and period_valid SHALL be 1 from the next cycle.
REQ-021 On a rise in IDLE or STALLED, period SHALL NOT update.
REQ-022 On entry to STALLED, period_valid SHALL clear; period retains its last value.
REQ-023 A rise and timeout in the same cycle SHALL be treated as a rise (no stall).
REQ-024 locked and stalled SHALL be registered decodes of the state, never both 1.

Reset
REQ-025 reset SHALL asynchronously clear synchronizer flops, p, cnt, period, and all outputs to 0, and set state IDLE.
REQ-026 Reset asserted mid-measurement SHALL discard the partial interval; the first rise after release SHALL only enter MEASURE.

Configuration
REQ-027 Macro CLK_SLOW_MON_JITTER_CHECK_EN SHALL enable period comparison.
REQ-028 With the macro defined, a rise in LOCKED whose new period differs from the stored period SHALL pulse period_err for one cycle, aligned with the period update.
REQ-029 Without the macro, period_err SHALL be constant 0 and no comparison logic SHALL be synthesized.

Verification
REQ-030 clk_sys_in toggling every 4 clk cycles after reset -> rise_tick every 8 cycles, locked after 2nd rise, period = 8, period_valid = 1.
REQ-031 Single clk_sys_in 0->1 -> rise_tick high exactly SYNC_STAGES+1 = 3 cycles after first sampling edge, width 1 cycle; fall_tick likewise on 1->0.
REQ-032 TIMEOUT = 20, clk_sys_in held after lock at period 8 -> stalled = 1, locked = 0, period_valid = 0, period still 8; next rise -> MEASURE, second rise -> LOCKED.
REQ-033 Half-period changed from 4 to 5 while LOCKED, macro defined -> period = 10, period_err pulses once; macro undefined -> period_err stays 0.
REQ-034 reset pulsed between two rises while LOCKED -> all outputs 0 immediately; the following rise gives no period update, the next gives period_valid = 1.
REQ-035 TIMEOUT = 8 and rise arriving on the cycle cnt reaches 8 -> no stall, period = 8.
